// File: rtl/serial_resp_pkg.sv
// Shared definitions for the serial register responder.
// State encodings, command-byte layout and reply codes.
package serial_resp_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CMD       = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_REG_WR    = 3'd3,
        S_RD_WAIT   = 3'd4,
        S_SEND      = 3'd5
    } state_e;

    localparam int unsigned CMD_WR_BIT   = 7;
    localparam logic [7:0]  ACK_BYTE_DEF = 8'h06;
    localparam logic [7:0]  NAK_BYTE     = 8'h15;

endpackage

// File: rtl/serial_timeout_ctr.sv
// Idle-cycle counter that flags when a wait has run for CYCLES cycles.
// expired is combinational so the caller can act in the same cycle.
module serial_timeout_ctr #(
    parameter int unsigned CYCLES = 16,
    parameter int unsigned W      = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired = enable && (cnt_q == W'(CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_reg_responder.sv
// Serial-link register responder: one command in, one reply byte out.
// Optional write-data timeout enabled by defining SERIAL_RESP_TIMEOUT_EN.
module serial_reg_responder
    import serial_resp_pkg::*;
#(
    parameter logic [7:0]  ACK_BYTE       = ACK_BYTE_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned TIMEOUT_W      = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_rd_strobe,
    output logic [7:0] tx_data,
    output logic       tx_wr_strobe,
    input  logic       tx_busy,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wr_data,
    output logic       reg_wr_strobe,
    output logic       reg_rd_strobe,
    input  logic [7:0] reg_rd_data,
    output logic       timeout_err
);

    state_e     state_q, state_d;
    logic       wr_flag_q, wr_flag_d;
    logic [7:0] reply_q, reply_d;
    logic [6:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wr_data_q, reg_wr_data_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       rx_rd_q, rx_rd_d;
    logic       tx_wr_q, tx_wr_d;
    logic       reg_wr_q, reg_wr_d;
    logic       reg_rd_q, reg_rd_d;
    logic       unused_cfg;

`ifdef SERIAL_RESP_TIMEOUT_EN
    logic tmo_clear, tmo_enable, tmo_expired;
    logic timeout_err_q, timeout_err_d;

    assign tmo_enable = (state_q == S_WAIT_DATA) && !rx_valid;

    serial_timeout_ctr #(
        .CYCLES (TIMEOUT_CYCLES),
        .W      (TIMEOUT_W)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    assign timeout_err = timeout_err_q;
    // NAK is reserved for a future error reply
    assign unused_cfg  = ^NAK_BYTE;
`else
    assign timeout_err = 1'b0;
    assign unused_cfg  = ^{NAK_BYTE, TIMEOUT_W'(TIMEOUT_CYCLES)};
`endif

    always_comb begin
        state_d       = state_q;
        wr_flag_d     = wr_flag_q;
        reply_d       = reply_q;
        reg_addr_d    = reg_addr_q;
        reg_wr_data_d = reg_wr_data_q;
        tx_data_d     = tx_data_q;
        rx_rd_d       = 1'b0;
        tx_wr_d       = 1'b0;
        reg_wr_d      = 1'b0;
        reg_rd_d      = 1'b0;
`ifdef SERIAL_RESP_TIMEOUT_EN
        tmo_clear     = 1'b0;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    reg_addr_d = rx_data[6:0];
                    wr_flag_d  = rx_data[CMD_WR_BIT];
                    rx_rd_d    = 1'b1;
                    state_d    = S_CMD;
                end
            end
            S_CMD: begin
                if (wr_flag_q) begin
`ifdef SERIAL_RESP_TIMEOUT_EN
                    tmo_clear = 1'b1;
`endif
                    state_d = S_WAIT_DATA;
                end else begin
                    reg_rd_d = 1'b1;
                    state_d  = S_RD_WAIT;
                end
            end
            S_WAIT_DATA: begin
                if (rx_valid) begin
                    reg_wr_data_d = rx_data;
                    rx_rd_d       = 1'b1;
                    state_d       = S_REG_WR;
                end
`ifdef SERIAL_RESP_TIMEOUT_EN
                else if (tmo_expired) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end
`endif
            end
            S_REG_WR: begin
                reg_wr_d = 1'b1;
                reply_d  = ACK_BYTE;
                state_d  = S_SEND;
            end
            S_RD_WAIT: begin
                reply_d = reg_rd_data;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_data_d = reply_q;
                    tx_wr_d   = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wr_flag_q     <= 1'b0;
            reply_q       <= '0;
            reg_addr_q    <= '0;
            reg_wr_data_q <= '0;
            tx_data_q     <= '0;
            rx_rd_q       <= 1'b0;
            tx_wr_q       <= 1'b0;
            reg_wr_q      <= 1'b0;
            reg_rd_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_flag_q     <= wr_flag_d;
            reply_q       <= reply_d;
            reg_addr_q    <= reg_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            tx_data_q     <= tx_data_d;
            rx_rd_q       <= rx_rd_d;
            tx_wr_q       <= tx_wr_d;
            reg_wr_q      <= reg_wr_d;
            reg_rd_q      <= reg_rd_d;
        end
    end

`ifdef SERIAL_RESP_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= timeout_err_d;
        end
    end
`endif

    assign rx_rd_strobe  = rx_rd_q;
    assign tx_data       = tx_data_q;
    assign tx_wr_strobe  = tx_wr_q;
    assign reg_addr      = reg_addr_q;
    assign reg_wr_data   = reg_wr_data_q;
    assign reg_wr_strobe = reg_wr_q;
    assign reg_rd_strobe = reg_rd_q;

endmodule
